frame_mapper: RTL and testbench

- Transmit-direction counterpart of the receive demapper.
- Pulls payload bytes from the client-side RX AXIS FIFO and builds fixed-size frames: FAS bytes, an overhead byte carrying the ARQ enable flag, payload, and a trailing CRC-8.
- Streams the frames byte-wise to the serial transmitter.
- Sits between the client FIFO and the serial transmitter in the TX path.

---
 rtl/frame_mapper.sv | 219 +++++++++++++++++++++
 tb/tb_frame_mapper.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mapper.sv
// frame_mapper: TX-direction frame builder.
// Pulls payload bytes from the client FIFO and emits fixed-size frames:
//   FAS0, FAS1, overhead {7'b0, arq}, payload (N-4 bytes), CRC-8,
// where N = ROWS*COLS. The bytes are streamed through a single output register
// with a valid/ready handshake. The register sustains one byte per cycle.
// Optional build macro FRAME_MAPPER_CRC_INJECT_EN adds i_crc_err_inject.
// When that input is high as the CRC byte is loaded, the transmitted CRC byte is inverted.
module frame_mapper #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 1024,
  parameter logic [7:0]  FAS0     = 8'hF6,
  parameter logic [7:0]  FAS1     = 8'h28,
  parameter logic [7:0]  CRC_POLY = 8'h07
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_pyld_data,
  input  logic       i_pyld_data_valid,
  output logic       o_pyld_data_req,
  input  logic       i_arq_en,
  input  logic       i_arq_en_valid,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_valid,
  output logic       o_frame_data_fas,
  input  logic       i_frame_data_ready,
`ifdef FRAME_MAPPER_CRC_INJECT_EN
  input  logic       i_crc_err_inject,
`endif
  output logic [7:0] o_crc_val
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [10:0]   COL_LAST = 11'(COLS - 1);
  localparam logic [10:0]   COL_PRE  = 11'(COLS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FAS,
    S_OH,
    S_PYLD,
    S_CRC
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q;
  logic [10:0]   col_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic          out_fas_q;
  logic [7:0]    crc_q;
  logic [7:0]    crc_val_q;
  logic          arq_q;

  logic          hs;
  logic          can_load;
  logic [RW-1:0] row_nxt, ld_row;
  logic [10:0]   col_nxt, ld_col;
  logic          arq_now;
  logic          load;
  logic [7:0]    ld_data;
  logic          ld_fas;
  logic          crc_clr;
  logic          crc_upd;
  logic          crc_cap;
  logic          pyld_req;
  logic [7:0]    crc_next;
  logic          crc_inject;

  // MSB-first CRC-8 step over one byte, no reflection, no final XOR
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

`ifdef FRAME_MAPPER_CRC_INJECT_EN
  assign crc_inject = i_crc_err_inject;
`else
  assign crc_inject = 1'b0;
`endif

  // Handshake and position bookkeeping.
  // The row/col counters track the byte currently presented, so the byte that
  // loads next sits one position further on whenever the register is occupied.
  always_comb begin
    hs       = out_valid_q & i_frame_data_ready;
    can_load = ~out_valid_q | i_frame_data_ready;
    col_nxt  = (col_q == COL_LAST) ? '0 : col_q + 11'd1;
    if (col_q == COL_LAST) begin
      row_nxt = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
    end else begin
      row_nxt = row_q;
    end
    ld_col   = out_valid_q ? col_nxt : col_q;
    ld_row   = out_valid_q ? row_nxt : row_q;
    arq_now  = i_arq_en_valid ? i_arq_en : arq_q;
    crc_next = crc8_byte(crc_q, ld_data);
  end

  // Next-state and load-control decode
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    ld_data  = '0;
    ld_fas   = 1'b0;
    crc_clr  = 1'b0;
    crc_upd  = 1'b0;
    crc_cap  = 1'b0;
    pyld_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_pyld_data_valid) state_d = S_FAS;
      end
      S_FAS: begin
        if (can_load) begin
          load    = 1'b1;
          crc_clr = 1'b1;
          if (ld_col == '0) begin
            ld_data = FAS0;
            ld_fas  = 1'b1;
          end else begin
            ld_data = FAS1;
            state_d = S_OH;
          end
        end
      end
      S_OH: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = {7'b0, arq_now};
          crc_upd = 1'b1;
          state_d = S_PYLD;
        end
      end
      S_PYLD: begin
        pyld_req = can_load;
        if (can_load && i_pyld_data_valid) begin
          load    = 1'b1;
          ld_data = i_pyld_data;
          crc_upd = 1'b1;
          if (ld_row == ROW_LAST && ld_col == COL_PRE) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = crc_inject ? ~crc_q : crc_q;
          crc_cap = 1'b1;
          state_d = i_pyld_data_valid ? S_FAS : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Output register: load when empty or draining, otherwise clear on handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_fas_q   <= 1'b0;
    end else if (load) begin
      out_data_q  <= ld_data;
      out_valid_q <= 1'b1;
      out_fas_q   <= ld_fas;
    end else if (hs) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_fas_q   <= 1'b0;
    end
  end

  // Row/column position of the presented byte, advanced per output handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (hs) begin
      row_q <= row_nxt;
      col_q <= col_nxt;
    end
  end

  // Running CRC over overhead and payload bytes as they load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     crc_q <= '0;
    else if (crc_clr) crc_q <= '0;
    else if (crc_upd) crc_q <= crc_next;
  end

  // Reported CRC: captured as the CRC byte loads, always the true value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     crc_val_q <= '0;
    else if (crc_cap) crc_val_q <= crc_q;
  end

  // ARQ flag latch, persists across frames until the next strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            arq_q <= 1'b0;
    else if (i_arq_en_valid) arq_q <= i_arq_en;
  end

  assign o_pyld_data_req    = pyld_req;
  assign o_frame_data       = out_data_q;
  assign o_frame_data_valid = out_valid_q;
  assign o_frame_data_fas   = out_fas_q;
  assign o_crc_val          = crc_val_q;

endmodule

// File: tb/tb_frame_mapper.sv
// tb_frame_mapper: directed self-checking bench for frame_mapper (ROWS=2, COLS=8).
// Exercises the FRAME_MAPPER_CRC_INJECT_EN path when that macro is defined.
module tb_frame_mapper;
  localparam int ROWS = 2;
  localparam int COLS = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_pyld_data = '0;
  logic       i_pyld_data_valid = 1'b0;
  logic       o_pyld_data_req;
  logic       i_arq_en = 1'b0;
  logic       i_arq_en_valid = 1'b0;
  logic [7:0] o_frame_data;
  logic       o_frame_data_valid;
  logic       o_frame_data_fas;
  logic       i_frame_data_ready = 1'b1;
  logic [7:0] o_crc_val;
`ifdef FRAME_MAPPER_CRC_INJECT_EN
  logic       i_crc_err_inject = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  frame_mapper #(
    .ROWS(ROWS), .COLS(COLS), .FAS0(8'hF6), .FAS1(8'h28), .CRC_POLY(8'h07)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_pyld_data(i_pyld_data),
    .i_pyld_data_valid(i_pyld_data_valid),
    .o_pyld_data_req(o_pyld_data_req),
    .i_arq_en(i_arq_en),
    .i_arq_en_valid(i_arq_en_valid),
    .o_frame_data(o_frame_data),
    .o_frame_data_valid(o_frame_data_valid),
    .o_frame_data_fas(o_frame_data_fas),
    .i_frame_data_ready(i_frame_data_ready),
`ifdef FRAME_MAPPER_CRC_INJECT_EN
    .i_crc_err_inject(i_crc_err_inject),
`endif
    .o_crc_val(o_crc_val)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  logic [7:0] src_q[$];
  logic [7:0] out_q[$];
  bit         fas_q[$];
  int         cyc_q[$];
  bit         pop_pend = 1'b0;
  int         starve_cnt = 0;
  bit         ready_mode = 1'b0;

  logic [7:0] pay[0:23];
  logic [7:0] exp_f[0:31];
  logic [7:0] exp_crc[0:1];

  always @(posedge i_clk) cycle <= cycle + 1;

  // Client FIFO model and ready pattern, updated just after each rising edge
  always @(posedge i_clk) begin
    #1;
    if (pop_pend && src_q.size() > 0) void'(src_q.pop_front());
    if (starve_cnt > 0) begin
      starve_cnt--;
      i_pyld_data_valid = 1'b0;
    end else begin
      i_pyld_data_valid = (src_q.size() > 0);
    end
    i_pyld_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
    i_frame_data_ready = ready_mode ? ~i_frame_data_ready : 1'b1;
  end

  // Output capture, sampled mid-cycle
  always @(negedge i_clk) begin
    pop_pend = i_pyld_data_valid && o_pyld_data_req;
    if (o_frame_data_valid && i_frame_data_ready) begin
      out_q.push_back(o_frame_data);
      fas_q.push_back(o_frame_data_fas);
      cyc_q.push_back(cycle);
    end
  end

  function automatic logic [7:0] model_crc(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic fb;
    r = c;
    for (int b = 7; b >= 0; b--) begin
      fb = r[7] ^ d[b];
      r = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic build_frame(input int f, input bit arq);
    logic [7:0] c;
    exp_f[f*16]     = 8'hF6;
    exp_f[f*16 + 1] = 8'h28;
    exp_f[f*16 + 2] = {7'b0, arq};
    c = model_crc(8'h00, {7'b0, arq});
    for (int i = 0; i < 12; i++) begin
      exp_f[f*16 + 3 + i] = pay[f*12 + i];
      c = model_crc(c, pay[f*12 + i]);
    end
    exp_f[f*16 + 15] = c;
    exp_crc[f] = c;
  endtask

  task automatic load_src(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(pay[i]);
  endtask

  task automatic clear_mon();
    out_q.delete();
    fas_q.delete();
    cyc_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge i_clk);
      #1;
      if (out_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic strobe_arq(input bit v);
    @(posedge i_clk);
    #2;
    i_arq_en = v;
    i_arq_en_valid = 1'b1;
    @(posedge i_clk);
    #2;
    i_arq_en_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    checks++; if (o_frame_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h expected 00", o_frame_data); end
    checks++; if (o_frame_data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b expected 0", o_frame_data_valid); end
    checks++; if (o_frame_data_fas !== 1'b0) begin failures++; $display("FAIL reset_fas got %b expected 0", o_frame_data_fas); end
    checks++; if (o_pyld_data_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b expected 0", o_pyld_data_req); end
    checks++; if (o_crc_val !== 8'h00) begin failures++; $display("FAIL reset_crc got %h expected 00", o_crc_val); end
    i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    #1;
    checks++; if (o_frame_data_valid !== 1'b0) begin failures++; $display("FAIL idle_no_data got valid=%b expected 0", o_frame_data_valid); end
  endtask

  task automatic test_all_zero();
    bit ok;
    for (int i = 0; i < 12; i++) pay[i] = 8'h00;
    build_frame(0, 1'b0);
    clear_mon();
    load_src(12);
    wait_bytes(16, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_timeout got %0d bytes expected 16", out_q.size()); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL zero_byte[%0d] got %h expected %h", i, out_q[i], exp_f[i]); end
        checks++; if (fas_q[i] !== (i == 0)) begin failures++; $display("FAIL zero_fas[%0d] got %b expected %b", i, fas_q[i], (i == 0)); end
      end
      checks++; if (cyc_q[15] - cyc_q[0] != 15) begin failures++; $display("FAIL zero_contig got span %0d expected 15", cyc_q[15] - cyc_q[0]); end
      checks++; if (o_crc_val !== 8'h00) begin failures++; $display("FAIL zero_crc_val got %h expected 00", o_crc_val); end
    end
    repeat (10) @(negedge i_clk);
    #1;
    checks++; if (o_frame_data_valid !== 1'b0) begin failures++; $display("FAIL zero_idle_valid got %b expected 0", o_frame_data_valid); end
    checks++; if (out_q.size() != 16) begin failures++; $display("FAIL zero_idle_count got %0d expected 16", out_q.size()); end
  endtask

  task automatic test_arq();
    bit ok;
    strobe_arq(1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 12; i++) pay[i] = (f == 0) ? 8'(i + 1) : 8'(8'h10 + i);
      build_frame(0, 1'b1);
      clear_mon();
      load_src(12);
      wait_bytes(16, 100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL arq%0d_timeout got %0d bytes expected 16", f, out_q.size()); end
      if (ok) begin
        checks++; if (out_q[2] !== 8'h01) begin failures++; $display("FAIL arq%0d_overhead got %h expected 01", f, out_q[2]); end
        for (int i = 0; i < 16; i++) begin
          checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL arq%0d_byte[%0d] got %h expected %h", f, i, out_q[i], exp_f[i]); end
        end
        checks++; if (o_crc_val !== exp_crc[0]) begin failures++; $display("FAIL arq%0d_crc_val got %h expected %h", f, o_crc_val, exp_crc[0]); end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit held;
    logic [7:0] held_data;
    int stalls;
    ok = 1'b0; held = 1'b0; held_data = '0; stalls = 0;
    for (int i = 0; i < 12; i++) pay[i] = 8'(i + 1);
    build_frame(0, 1'b1);
    clear_mon();
    ready_mode = 1'b1;
    load_src(12);
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge i_clk);
      if (held) begin
        stalls++;
        checks++;
        if (o_frame_data_valid !== 1'b1 || o_frame_data !== held_data) begin
          failures++;
          $display("FAIL bp_hold got valid=%b data=%h expected valid=1 data=%h", o_frame_data_valid, o_frame_data, held_data);
        end
      end
      held = o_frame_data_valid && !i_frame_data_ready;
      held_data = o_frame_data;
      #1;
      if (out_q.size() >= 16) ok = 1'b1;
    end
    ready_mode = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got %0d bytes expected 16", out_q.size()); end
    checks++; if (stalls < 4) begin failures++; $display("FAIL bp_stall_count got %0d expected >=4", stalls); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL bp_byte[%0d] got %h expected %h", i, out_q[i], exp_f[i]); end
      end
      checks++; if (o_crc_val !== exp_crc[0]) begin failures++; $display("FAIL bp_crc_val got %h expected %h", o_crc_val, exp_crc[0]); end
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_starve();
    bit ok;
    for (int i = 0; i < 12; i++) pay[i] = 8'(i + 1);
    build_frame(0, 1'b1);
    clear_mon();
    load_src(12);
    wait_bytes(6, 100, ok);
    starve_cnt = 5;
    wait_bytes(16, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL starve_timeout got %0d bytes expected 16", out_q.size()); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL starve_byte[%0d] got %h expected %h", i, out_q[i], exp_f[i]); end
      end
      checks++; if (cyc_q[15] - cyc_q[0] != 20) begin failures++; $display("FAIL starve_gap got span %0d expected 20", cyc_q[15] - cyc_q[0]); end
      checks++; if (o_crc_val !== exp_crc[0]) begin failures++; $display("FAIL starve_crc_val got %h expected %h", o_crc_val, exp_crc[0]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 24; i++) pay[i] = 8'(8'h30 + i);
    build_frame(0, 1'b1);
    build_frame(1, 1'b1);
    clear_mon();
    load_src(24);
    wait_bytes(32, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got %0d bytes expected 32", out_q.size()); end
    if (ok) begin
      for (int i = 0; i < 32; i++) begin
        checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL b2b_byte[%0d] got %h expected %h", i, out_q[i], exp_f[i]); end
      end
      checks++; if (cyc_q[16] - cyc_q[15] != 1) begin failures++; $display("FAIL b2b_seam got gap %0d expected 1", cyc_q[16] - cyc_q[15]); end
      checks++; if (cyc_q[31] - cyc_q[0] != 31) begin failures++; $display("FAIL b2b_span got %0d expected 31", cyc_q[31] - cyc_q[0]); end
      checks++; if (fas_q[16] !== 1'b1) begin failures++; $display("FAIL b2b_fas2 got %b expected 1", fas_q[16]); end
      checks++; if (o_crc_val !== exp_crc[1]) begin failures++; $display("FAIL b2b_crc_val got %h expected %h", o_crc_val, exp_crc[1]); end
    end
    repeat (10) @(negedge i_clk);
    #1;
    checks++; if (o_frame_data_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got %b expected 0", o_frame_data_valid); end
    checks++; if (out_q.size() != 32) begin failures++; $display("FAIL b2b_idle_count got %0d expected 32", out_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int i = 0; i < 12; i++) pay[i] = 8'(8'h50 + i);
    clear_mon();
    load_src(12);
    wait_bytes(7, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach got %0d bytes expected 7", out_q.size()); end
    i_rst_n = 1'b0;
    pop_pend = 1'b0;
    #1;
    checks++; if (o_frame_data_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b expected 0", o_frame_data_valid); end
    checks++; if (o_frame_data !== 8'h00) begin failures++; $display("FAIL rstmid_data got %h expected 00", o_frame_data); end
    checks++; if (o_frame_data_fas !== 1'b0) begin failures++; $display("FAIL rstmid_fas got %b expected 0", o_frame_data_fas); end
    checks++; if (o_pyld_data_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got %b expected 0", o_pyld_data_req); end
    checks++; if (o_crc_val !== 8'h00) begin failures++; $display("FAIL rstmid_crc_val got %h expected 00", o_crc_val); end
    src_q.delete();
    for (int i = 0; i < 12; i++) pay[i] = 8'(8'h60 + i);
    build_frame(0, 1'b0);
    load_src(12);
    clear_mon();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_bytes(16, 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got %0d bytes expected 16", out_q.size()); end
    if (ok) begin
      checks++; if (fas_q[0] !== 1'b1) begin failures++; $display("FAIL rstmid_first_fas got %b expected 1", fas_q[0]); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL rstmid_byte[%0d] got %h expected %h", i, out_q[i], exp_f[i]); end
      end
    end
  endtask

`ifdef FRAME_MAPPER_CRC_INJECT_EN
  task automatic test_crc_inject();
    bit ok;
    for (int i = 0; i < 12; i++) pay[i] = 8'h00;
    build_frame(0, 1'b0);
    exp_f[15] = ~exp_crc[0];
    i_crc_err_inject = 1'b1;
    clear_mon();
    load_src(12);
    wait_bytes(16, 100, ok);
    i_crc_err_inject = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL inject_timeout got %0d bytes expected 16", out_q.size()); end
    if (ok) begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (out_q[i] !== exp_f[i]) begin failures++; $display("FAIL inject_byte[%0d] got %h expected %h", i, out_q[i], exp_f[i]); end
      end
      checks++; if (o_crc_val !== 8'h00) begin failures++; $display("FAIL inject_crc_val got %h expected 00", o_crc_val); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_zero();
    test_arq();
    test_backpressure();
    test_starve();
    test_back_to_back();
    test_reset_mid();
`ifdef FRAME_MAPPER_CRC_INJECT_EN
    test_crc_inject();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit expected completion");
    $fatal(1, "watchdog");
  end

endmodule
